pwm_update_sched: RTL and testbench

- Arbitrates duty-cycle update requests from several software or hardware requesters, for example the steering and throttle loops.
- Holds each update in a per-channel shadow register.
- Commits all pending updates to the pwm_gen register file as a burst of single-cycle register writes, triggered by the core's period-end pulse.
- Placement: between the requesters and the pwm_gen register write port. Duty changes therefore land only at period boundaries, and PWM periods are never glitched.

---
 rtl/pwm_update_sched.sv | 142 ++++++++++++++
 tb/tb_pwm_update_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_sched.sv
// Collects duty-cycle updates from several requesters into per-channel shadow registers
// and commits the dirty ones to the pwm_gen register file as a burst at each period end.
module pwm_update_sched #(
  parameter int N_REQ  = 2,
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*CH_W-1:0]      req_chan,
  input  logic [N_REQ*DATA_W-1:0]    req_duty,
  input  logic                       period_end,
  output logic                       core_wr_en,
  output logic [ADDR_W-1:0]          core_wr_addr,
  output logic [DATA_W-1:0]          core_wr_data,
  output logic                       busy,
  output logic [N_CH-1:0]            pending,
  output logic                       err_chan,
  output logic                       commit_overrun
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_gnt_idx, w_ptr_nxt;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_req_ch, w_sel_ch;
  logic [DATA_W-1:0]   w_req_duty;
  logic                w_in_range;
  logic [N_CH-1:0]     r_dirty, r_flush_mask;
  logic [N_CH-1:0]     w_acc_mask, w_dirty_nxt, w_sel_mask, w_flush_left;
  logic [DATA_W-1:0]   r_shadow [N_CH];
  logic                r_wr_en, r_err, r_ovr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  // Round-robin search starts at r_rr_ptr; grants only while idle.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    req_ready = '0;
    if (r_state == IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_gnt_vld && req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
        end
      end
    end
    if (w_gnt_vld) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_nxt  = PTR_W'((int'(w_gnt_idx) + 1) % N_REQ);
  assign w_req_ch   = req_chan[int'(w_gnt_idx)*CH_W +: CH_W];
  assign w_req_duty = req_duty[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_in_range = (int'(w_req_ch) < N_CH);

  // Dirty mask as it will be after this cycle's accepted update, so a same-cycle
  // update is included in a flush triggered by the same period_end.
  always_comb begin
    w_acc_mask = '0;
    if (w_gnt_vld && w_in_range) w_acc_mask[w_req_ch] = 1'b1;
    w_dirty_nxt = r_dirty | w_acc_mask;
  end

  always_comb begin
    w_sel_ch = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (r_flush_mask[c]) w_sel_ch = CH_W'(c);
    end
    w_sel_mask = '0;
    w_sel_mask[w_sel_ch] = 1'b1;
    w_flush_left = r_flush_mask & ~w_sel_mask;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (period_end && (|w_dirty_nxt)) w_state_nxt = FLUSH;
      FLUSH:   if (w_flush_left == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rr_ptr     <= '0;
      r_dirty      <= '0;
      r_flush_mask <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
      r_ovr        <= 1'b0;
      for (int c = 0; c < N_CH; c++) r_shadow[c] <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
      if (r_state == IDLE) begin
        if (w_gnt_vld) begin
          r_rr_ptr <= w_ptr_nxt;
          if (w_in_range) r_shadow[w_req_ch] <= w_req_duty;
          else            r_err <= 1'b1;
        end
        if (period_end && (|w_dirty_nxt)) begin
          r_flush_mask <= w_dirty_nxt;
          r_dirty      <= '0;
        end else begin
          r_dirty <= w_dirty_nxt;
        end
      end else begin
        // One register write per cycle, lowest channel first.
        r_wr_en      <= 1'b1;
        r_wr_addr    <= ADDR_W'({w_sel_ch, 2'b00});
        r_wr_data    <= r_shadow[w_sel_ch];
        r_flush_mask <= w_flush_left;
        if (period_end) r_ovr <= 1'b1;
      end
    end
  end

  assign core_wr_en     = r_wr_en;
  assign core_wr_addr   = r_wr_addr;
  assign core_wr_data   = r_wr_data;
  assign busy           = (r_state == FLUSH);
  assign pending        = r_dirty;
  assign err_chan       = r_err;
  assign commit_overrun = r_ovr;

endmodule

// File: tb/tb_pwm_update_sched.sv
// Directed testbench for pwm_update_sched with hand-computed expected values.
module tb_pwm_update_sched;

  localparam int N_REQ  = 2;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic                    ACLK = 1'b0;
  logic                    ARESETN;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*CH_W-1:0]   req_chan;
  logic [N_REQ*DATA_W-1:0] req_duty;
  logic                    period_end;
  logic                    core_wr_en;
  logic [ADDR_W-1:0]       core_wr_addr;
  logic [DATA_W-1:0]       core_wr_data;
  logic                    busy;
  logic [N_CH-1:0]         pending;
  logic                    err_chan;
  logic                    commit_overrun;

  int n_cmp = 0;
  int n_mis = 0;

  pwm_update_sched #(
    .N_REQ(N_REQ), .N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_duty(req_duty),
    .period_end(period_end),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .busy(busy), .pending(pending),
    .err_chan(err_chan), .commit_overrun(commit_overrun)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN    = 1'b0;
    req_valid  = '0;
    req_chan   = '0;
    req_duty   = '0;
    period_end = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  task automatic send(input int r, input int ch, input logic [DATA_W-1:0] d);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_chan[r*CH_W +: CH_W]     = CH_W'(ch);
    req_duty[r*DATA_W +: DATA_W] = d;
    #1;
    check_eq("send_ready", req_ready, 64'(1 << r));
    tick();
    req_valid = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wr_en"},   core_wr_en, 0);
    check_eq({tag, "_addr"},    core_wr_addr, 0);
    check_eq({tag, "_data"},    core_wr_data, 0);
    check_eq({tag, "_busy"},    busy, 0);
    check_eq({tag, "_pending"}, pending, 0);
    check_eq({tag, "_err"},     err_chan, 0);
    check_eq({tag, "_ovr"},     commit_overrun, 0);
    check_eq({tag, "_ready"},   req_ready, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d [4];
    int strobes;

    // Reset sequence: 200 ns low, then release.
    ARESETN    = 1'b0;
    req_valid  = '0;
    req_chan   = '0;
    req_duty   = '0;
    period_end = 1'b0;
    #100;
    check_idle_outputs("in_reset");
    #100;
    ARESETN = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Single update to channel 2.
    send(0, 2, 32'h80);
    check_eq("single_pending", pending, 4'b0100);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("single_busy_entry", busy, 1);
    check_eq("single_no_early_strobe", core_wr_en, 0);
    check_eq("single_pending_clr", pending, 0);
    tick();
    check_eq("single_wr_en", core_wr_en, 1);
    check_eq("single_addr", core_wr_addr, 4'h8);
    check_eq("single_data", core_wr_data, 32'h80);
    check_eq("single_busy_done", busy, 0);
    tick();
    check_eq("single_wr_en_drop", core_wr_en, 0);
    check_eq("single_addr_hold", core_wr_addr, 4'h8);

    // Round robin under continuous contention.
    do_reset();
    req_valid = 2'b11;
    req_chan  = {2'd1, 2'd0};
    req_duty  = {32'hB1, 32'hA0};
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_grant%0d", i), req_ready, (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    req_valid = '0;
    check_eq("rr_pending", pending, 4'b0011);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    tick();
    check_eq("rr_flush0_addr", core_wr_addr, 4'h0);
    check_eq("rr_flush0_data", core_wr_data, 32'hA0);
    tick();
    check_eq("rr_flush1_addr", core_wr_addr, 4'h4);
    check_eq("rr_flush1_data", core_wr_data, 32'hB1);

    // Full flush with coalescing on channel 3.
    do_reset();
    send(0, 3, 32'h33);
    send(0, 0, 32'h11);
    send(0, 3, 32'h44);
    send(0, 1, 32'h22);
    send(0, 2, 32'h55);
    check_eq("full_pending", pending, 4'b1111);
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h55; exp_d[3] = 32'h44;
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    req_valid  = 2'b11;
    #1;
    check_eq("full_ready_entry", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("full_wr_en%0d", k), core_wr_en, 1);
      check_eq($sformatf("full_addr%0d", k), core_wr_addr, 64'(k * 4));
      check_eq($sformatf("full_data%0d", k), core_wr_data, exp_d[k]);
      if (k < 3) check_eq($sformatf("full_ready%0d", k), req_ready, 0);
    end
    req_valid = '0;
    tick();
    check_eq("full_wr_en_end", core_wr_en, 0);
    check_eq("full_pending_end", pending, 0);
    check_eq("full_err", err_chan, 0);

    // Update accepted in the same cycle as period_end, then overrun.
    do_reset();
    req_valid  = 2'b01;
    req_chan   = {2'd0, 2'd1};
    req_duty   = {32'h0, 32'h77};
    period_end = 1'b1;
    #1;
    check_eq("sim_ready", req_ready, 1);
    tick();
    req_valid = '0;
    check_eq("sim_busy", busy, 1);
    check_eq("sim_pending", pending, 0);
    tick();
    period_end = 1'b0;
    check_eq("sim_wr_en", core_wr_en, 1);
    check_eq("sim_addr", core_wr_addr, 4'h4);
    check_eq("sim_data", core_wr_data, 32'h77);
    check_eq("sim_overrun", commit_overrun, 1);
    tick();
    check_eq("sim_overrun_pulse", commit_overrun, 0);
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      if (core_wr_en) strobes++;
      tick();
    end
    check_eq("sim_extra_strobes", strobes, 0);
    check_eq("sim_busy_end", busy, 0);

    // Reset during the second cycle of a four-channel flush.
    do_reset();
    for (int c = 0; c < 4; c++) send(0, c, 32'h10 + 32'(c));
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    tick();
    check_eq("abort_first_strobe", core_wr_en, 1);
    check_eq("abort_first_addr", core_wr_addr, 4'h0);
    ARESETN = 1'b0;
    #1;
    check_eq("abort_wr_en", core_wr_en, 0);
    check_eq("abort_pending", pending, 0);
    check_eq("abort_busy", busy, 0);
    repeat (2) tick();
    ARESETN = 1'b1;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (core_wr_en) strobes++;
    end
    check_eq("abort_no_writes", strobes, 0);
    check_eq("abort_pending_after", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
